mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter GAP_CYC, default 4, turnaround idle cycles between grants (range 1..15).
REQ-002 SHALL have parameter RD_RUN_MAX, default 2, consecutive read grants allowed while a write is pending (range 1..15).
REQ-003 SHALL have parameter TIMEOUT, default 4095, grant cycles allowed before abort (12-bit, 1..4095).
REQ-004 Clock and reset: the block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 memclk  in  1  memory-controller clock; all logic on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 rd_req  in  1  read requester (display line fetch) wants the MCB port; level.
REQ-008 wr_req  in  1  write requester (capture) wants the MCB port; level.
REQ-009 rd_done  in  1  read requester memcon_donep; may stay high several cycles.
REQ-010 wr_done  in  1  write requester memcon_donep; same semantics.
REQ-011 wr_vs, rd_vs  in  1 each  capture/display vsync, already synchronous to memclk.
REQ-012 rd_en, wr_en  out  1 each  memcon_en grant to the read/write requester.
REQ-013 arb_state  out  2  00 = IDLE or RD, 01 = WR, 10 = GAP, 11 = unused.
REQ-014 wr_frame, rd_frame  out  1 each  ping-pong frame-buffer index for the writer/reader.
REQ-015 timeout_err  out  1  sticky; set on any grant timeout.

Function
REQ-016 SHALL implement FSM IDLE, RD, WR, GAP; all outputs registered.
REQ-017 IDLE: if rd_req and (not wr_req or rd_run < RD_RUN_MAX) -> RD, rd_en=1 next cycle; else if wr_req -> WR, wr_en=1; else stay.
REQ-018 IDLE SHALL NOT grant while rd_done or wr_done is high.
REQ-019 rd_run (4-bit) SHALL increment on each RD entry, clear on each WR entry, and saturate at 15.
REQ-020 RD: rd_en held high until rd_done sampled high; then rd_en=0, -> GAP on the same edge.
REQ-021 WR: symmetric using wr_en/wr_done.
REQ-022 GAP: SHALL last at least GAP_CYC cycles and until rd_done and wr_done are both low, then -> IDLE.
REQ-023 Grant counter SHALL clear on RD/WR entry and count each grant cycle; reaching TIMEOUT without done SHALL drop the grant, set timeout_err, and -> GAP.
REQ-024 Exactly one of rd_en/wr_en SHALL ever be high; both low in IDLE and GAP.
REQ-025 Rising edge of wr_vs SHALL request a wr_frame toggle; outside WR the toggle occurs next cycle, in WR it is deferred to WR exit.
REQ-026 Rising edge of rd_vs SHALL set rd_frame <= ~wr_frame (value after any same-cycle toggle).
REQ-027 Multiple wr_vs edges during one WR grant SHALL produce a single toggle.
REQ-028 Requests dropping during RD/WR SHALL NOT end the grant; only done or timeout does.

Reset
REQ-029 rst SHALL force IDLE immediately and clear rd_en, wr_en, arb_state, rd_run, grant counter, pending toggle, wr_frame=0, rd_frame=1, timeout_err=0.
REQ-030 Reset mid-grant SHALL drop the grant asynchronously; first grant only after rst release and done inputs low.

Verification
REQ-031 rd_req=wr_req=1 continuously, done 3 cycles after each grant -> order RD,RD,WR,RD,RD,WR; arb_state 00/01/10 accordingly.
REQ-032 rd_done held high 5 cycles -> GAP lasts 5 cycles, not 4; next grant only after rd_done low.
REQ-033 WR granted, done never asserted, TIMEOUT=16 -> wr_en falls after 16 cycles, timeout_err=1 and stays 1.
REQ-034 wr_vs edge during WR -> wr_frame toggles one cycle after WR exit; next rd_vs edge -> rd_frame=~wr_frame.
REQ-035 rst asserted during RD -> rd_en=0, arb_state=00, wr_frame=0, rd_frame=1 with no clock edge.
REQ-036 Random rd_req/wr_req/done for 100k cycles -> rd_en&wr_en never both 1, no read-side starvation beyond RD_RUN_MAX+1 grants.

Source files
------------

// File: rtl/mem_arb.sv
// Two-requester MCB port arbiter: display reader vs capture writer, with
// turnaround gaps, read-run limiting, grant timeout and ping-pong frame indices.
module mem_arb #(
  parameter int GAP_CYC    = 4,
  parameter int RD_RUN_MAX = 2,
  parameter int TIMEOUT    = 4095
) (
  input  logic       memclk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic       rd_done,
  input  logic       wr_done,
  input  logic       wr_vs,
  input  logic       rd_vs,
  output logic       rd_en,
  output logic       wr_en,
  output logic [1:0] arb_state,
  output logic       wr_frame,
  output logic       rd_frame,
  output logic       timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_GAP} state_t;

  localparam logic [3:0]  GAP_LAST = 4'(GAP_CYC - 1);
  localparam logic [3:0]  RUN_MAX  = 4'(RD_RUN_MAX);
  localparam logic [11:0] TO_LAST  = 12'(TIMEOUT - 1);

  state_t      r_state, w_state_next;
  logic [3:0]  r_rd_run, w_rd_run_next;
  logic [11:0] r_gnt_cnt, w_gnt_cnt_next;
  logic [3:0]  r_gap_cnt, w_gap_cnt_next;
  logic        w_timeout;
  logic        w_done_any;
  logic        w_grant_done;

  logic        r_rd_en, r_wr_en;
  logic [1:0]  r_arb_state;
  logic        r_timeout_err;
  logic        r_wr_frame, r_rd_frame;
  logic        r_wr_pend;
  logic        r_wr_vs_d, r_rd_vs_d;
  logic        w_wr_vs_rise, w_rd_vs_rise;
  logic        w_wr_tgl, w_wr_frame_next;

  assign w_done_any   = rd_done | wr_done;
  assign w_grant_done = (r_state == S_RD) ? rd_done : wr_done;

  always_comb begin
    w_state_next   = r_state;
    w_rd_run_next  = r_rd_run;
    w_gnt_cnt_next = r_gnt_cnt;
    w_gap_cnt_next = r_gap_cnt;
    w_timeout      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // a lingering done from the previous owner must not be mistaken for a new one
        if (!w_done_any) begin
          if (rd_req && (!wr_req || (r_rd_run < RUN_MAX))) begin
            w_state_next   = S_RD;
            w_rd_run_next  = (r_rd_run == 4'd15) ? r_rd_run : r_rd_run + 4'd1;
            w_gnt_cnt_next = '0;
          end else if (wr_req) begin
            w_state_next   = S_WR;
            w_rd_run_next  = '0;
            w_gnt_cnt_next = '0;
          end
        end
      end
      S_RD, S_WR: begin
        if (w_grant_done) begin
          w_state_next   = S_GAP;
          w_gap_cnt_next = '0;
        end else if (r_gnt_cnt == TO_LAST) begin
          w_state_next   = S_GAP;
          w_gap_cnt_next = '0;
          w_timeout      = 1'b1;
        end else begin
          w_gnt_cnt_next = r_gnt_cnt + 12'd1;
        end
      end
      S_GAP: begin
        if ((r_gap_cnt >= GAP_LAST) && !w_done_any) begin
          w_state_next = S_IDLE;
        end else if (r_gap_cnt != 4'd15) begin
          w_gap_cnt_next = r_gap_cnt + 4'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A writer vsync seen mid-write is held until the write grant ends.
  assign w_wr_vs_rise    = wr_vs & ~r_wr_vs_d;
  assign w_rd_vs_rise    = rd_vs & ~r_rd_vs_d;
  assign w_wr_tgl        = (r_state != S_WR) && (w_wr_vs_rise || r_wr_pend);
  assign w_wr_frame_next = r_wr_frame ^ w_wr_tgl;

  always_ff @(posedge memclk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rd_run      <= '0;
      r_gnt_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_rd_en       <= 1'b0;
      r_wr_en       <= 1'b0;
      r_arb_state   <= 2'b00;
      r_timeout_err <= 1'b0;
      r_wr_frame    <= 1'b0;
      r_rd_frame    <= 1'b1;
      r_wr_pend     <= 1'b0;
      r_wr_vs_d     <= 1'b0;
      r_rd_vs_d     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rd_run    <= w_rd_run_next;
      r_gnt_cnt   <= w_gnt_cnt_next;
      r_gap_cnt   <= w_gap_cnt_next;
      r_rd_en     <= (w_state_next == S_RD);
      r_wr_en     <= (w_state_next == S_WR);
      r_arb_state <= (w_state_next == S_WR)  ? 2'b01 :
                     (w_state_next == S_GAP) ? 2'b10 : 2'b00;
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
      r_wr_vs_d  <= wr_vs;
      r_rd_vs_d  <= rd_vs;
      r_wr_pend  <= (r_state == S_WR) && (r_wr_pend || w_wr_vs_rise);
      r_wr_frame <= w_wr_frame_next;
      if (w_rd_vs_rise) begin
        r_rd_frame <= ~w_wr_frame_next;
      end
    end
  end

  assign rd_en       = r_rd_en;
  assign wr_en       = r_wr_en;
  assign arb_state   = r_arb_state;
  assign wr_frame    = r_wr_frame;
  assign rd_frame    = r_rd_frame;
  assign timeout_err = r_timeout_err;

endmodule
